// File: rtl/uart_rx_frame_fifo_pkg.sv
// Shared types and defaults for the UART receive frame buffer.
package uart_rx_pkg;

  localparam int RX_FIFO_DEPTH_DEF = 8;
  localparam int RX_DATA_W_DEF     = 8;

  typedef struct packed {
    logic                     stop_err;
    logic                     parity_err;
    logic [RX_DATA_W_DEF-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_frame_fifo_if.sv
// Head-of-FIFO valid/ready read channel between the frame buffer and the host.
interface uart_rx_frame_fifo_if #(
  parameter int DATA_W = 8
) ();

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_parity_err;
  logic              rd_stop_err;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_parity_err,
    output rd_stop_err,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_parity_err,
    input  rd_stop_err,
    output rd_ready
  );

endinterface

// File: rtl/uart_rx_frame_fifo_mem.sv
// Register-array frame storage: one synchronous write port, one asynchronous read port.
module rx_fifo_mem
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rx_entry_t     wr_entry,
  input  logic [AW-1:0] rd_addr,
  output rx_entry_t     rd_entry
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_entry;
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_fifo.sv
// Captures each completed Rx frame (rx_done rising edge) with its error flags into a
// first-word-fall-through FIFO; tracks occupancy, sticky overrun and frame acknowledge.
module uart_rx_frame_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH_DEF,
  parameter int DATA_W = RX_DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     parity_error_in,
  input  logic                     stop_bit_error_in,
  input  logic                     flush,
  input  logic                     clr_overrun,
  uart_rx_frame_fifo_if.master     rd_if,
  output logic                     frame_ack,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          rx_done_q;
  logic          push_req;
  logic          pop;
  logic          push_acc;
  logic          drop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  rx_entry_t     wr_entry;
  rx_entry_t     head;

  assign push_req = rx_done & ~rx_done_q;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop      = rd_if.rd_valid & rd_if.rd_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push_acc = push_req & ~flush & (~full | pop);
  assign drop     = push_req & ~flush & ~push_acc;

  always_comb begin
    wr_entry            = '0;
    wr_entry.stop_err   = stop_bit_error_in;
    wr_entry.parity_err = parity_error_in;
    wr_entry.data       = data_in;
  end

  rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .wr_en    (push_acc),
    .wr_addr  (wr_ptr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr),
    .rd_entry (head)
  );

  // rx_done_q resets high so a level already asserted at reset release is not a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_done_q <= 1'b1;
      frame_ack <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      frame_ack <= push_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  assign rd_if.rd_valid      = ~empty;
  assign rd_if.rd_data       = head.data;
  assign rd_if.rd_parity_err = head.parity_err;
  assign rd_if.rd_stop_err   = head.stop_err;

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed + randomized bench for uart_rx_frame_fifo against a queue-based reference model.
module tb_uart_rx_frame_fifo;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done = 1'b1;
  logic [7:0] data_in = '0;
  logic       parity_error_in = 1'b0;
  logic       stop_bit_error_in = 1'b0;
  logic       flush = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       frame_ack;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overrun;

  uart_rx_frame_fifo_if #(.DATA_W(DATA_W)) rd_if ();

  uart_rx_frame_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_done           (rx_done),
    .data_in           (data_in),
    .parity_error_in   (parity_error_in),
    .stop_bit_error_in (stop_bit_error_in),
    .flush             (flush),
    .clr_overrun       (clr_overrun),
    .rd_if             (rd_if),
    .frame_ack         (frame_ack),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {stop_err, parity_err, data}.
  logic [9:0] q [$];
  bit         m_ov;
  bit         m_ack;
  bit         m_prev;
  int         total  = 0;
  int         passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov   = 1'b0;
    m_ack  = 1'b0;
    m_prev = 1'b1;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".count"}, 32'(count), 32'(q.size()));
    chk({ph, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({ph, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({ph, ".rd_valid"}, 32'(rd_if.rd_valid), 32'(q.size() != 0));
    chk({ph, ".overrun"}, 32'(overrun), 32'(m_ov));
    chk({ph, ".frame_ack"}, 32'(frame_ack), 32'(m_ack));
    if (q.size() != 0)
      chk({ph, ".head"}, 32'({rd_if.rd_stop_err, rd_if.rd_parity_err, rd_if.rd_data}), 32'(q[0]));
  endtask

  // Apply the inputs currently driven for one clock, update the model, then compare.
  task automatic tick(input string ph);
    bit rise, pop, acc, drop;
    rise = rx_done && !m_prev;
    pop  = (q.size() != 0) && rd_if.rd_ready;
    acc  = 1'b0;
    drop = 1'b0;
    if (rise && !flush) begin
      if (q.size() < DEPTH || pop) acc = 1'b1;
      else                         drop = 1'b1;
    end
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({stop_bit_error_in, parity_error_in, data_in});
    end
    if (drop)             m_ov = 1'b1;
    else if (clr_overrun) m_ov = 1'b0;
    m_ack  = rise;
    m_prev = rx_done;
    @(posedge clk);
    #1;
    check_outputs(ph);
    @(negedge clk);
  endtask

  // One frame: rising edge of rx_done with data, then rx_done low for a cycle.
  task automatic frame(input string ph, input logic [7:0] d, input bit pe, input bit se,
                       input bit rdy);
    rx_done = 1'b1; data_in = d; parity_error_in = pe; stop_bit_error_in = se;
    rd_if.rd_ready = rdy;
    tick(ph);
    rx_done = 1'b0;
    tick(ph);
  endtask

  task automatic drain(input string ph, input int n);
    rx_done = 1'b0;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < n; i++) tick(ph);
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    model_reset();

    // Reset released while rx_done is already high: no capture, no ack.
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    tick("rst_hold_hi");
    tick("rst_hold_hi");

    // Three frames with distinct flags, consumer always ready.
    rx_done = 1'b0;
    tick("idle");
    frame("f41", 8'h41, 1'b0, 1'b0, 1'b1);
    frame("f42", 8'h42, 1'b1, 1'b0, 1'b1);
    frame("f43", 8'h43, 1'b0, 1'b1, 1'b1);
    drain("drain3", 2);

    // Fill to DEPTH, then one more frame is dropped and flags overrun.
    for (int i = 0; i < DEPTH; i++) frame("fill", 8'(i), 1'b0, 1'b0, 1'b0);
    frame("drop08", 8'h08, 1'b0, 1'b0, 1'b0);
    drain("drain8", DEPTH + 1);

    // Full FIFO: push coinciding with pop is accepted, count holds.
    for (int i = 0; i < DEPTH; i++)
      frame("fill2", 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    frame("pushpop09", 8'h09, 1'b0, 1'b0, 1'b1);
    drain("drain9", DEPTH + 1);

    // Overrun set wins over a simultaneous clear; clear alone then works.
    for (int i = 0; i < DEPTH; i++) frame("fill3", 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    clr_overrun = 1'b1;
    frame("clr_vs_set", 8'h99, 1'b0, 1'b0, 1'b0);
    tick("clr_alone");
    clr_overrun = 1'b0;

    // Flush with a simultaneous push discards it without overrun.
    flush = 1'b1;
    frame("flush55", 8'h55, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;

    // Asynchronous reset in the middle of filling.
    for (int i = 0; i < 3; i++) frame("prefill", 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    rx_done = 1'b0;
    tick("post_rst");

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      rx_done           = bit'($urandom_range(0, 1));
      data_in           = 8'($urandom_range(0, 255));
      parity_error_in   = bit'($urandom_range(0, 1));
      stop_bit_error_in = bit'($urandom_range(0, 1));
      rd_if.rd_ready    = ($urandom_range(0, 3) == 0);
      flush             = ($urandom_range(0, 31) == 0);
      clr_overrun       = ($urandom_range(0, 15) == 0);
      tick("rand");
    end
    flush = 1'b0;
    clr_overrun = 1'b0;
    drain("rand_drain", DEPTH + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
